gt_uint_serial_ctrl: RTL and testbench

//  Sequencer for a bit-serial unsigned greater-than test (A > B) that reuses one narrow

---
 rtl/gt_serial_pkg.sv | 21 ++
 rtl/gt_slice_chain.sv | 59 +++++
 rtl/gt_uint_serial_ctrl.sv | 105 ++++++++++
 tb/tb_gt_uint_serial_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_serial_pkg.sv
// Shared definitions for the bit-serial unsigned greater-than sequencer.
//   state_t    : controller state encoding (IDLE / RUN / DONE, 2 bits)
//   nstep()    : number of slice steps for a WIDTH / BITS_PER_CYCLE pair
//   cnt_width(): step-counter width, wide enough to hold NSTEP without wrapping
package gt_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned nstep(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
        return $clog2(nstep(width, bpc) + 1);
    endfunction

endpackage

// File: rtl/gt_slice_chain.sv
// Borrow-only subtractor cell and the BITS_PER_CYCLE-wide ripple built from it.
//
// subtractor_1bit_cmp: borrow out of (m - s - bin)
//   m, s, bin : minuend bit, subtrahend bit, borrow in
//   bout      : borrow out
//   IMPL_TYPE : 0 = sum-of-products form, otherwise a mux form (same function)
//
// gt_slice_chain: borrow out of (B - A - Bin) across one slice, LSB first.
//   A, B : slice bits of the compare operands (B is the minuend)
//   Bin  : borrow into bit 0
//   Bout : borrow out of the top bit; 1 iff {A} > {B} given Bin=0 over the full chain
module subtractor_1bit_cmp #(
    parameter int IMPL_TYPE = 0
) (
    input  logic m,
    input  logic s,
    input  logic bin,
    output logic bout
);

    generate
        if (IMPL_TYPE == 0) begin : g_sop
            assign bout = (~m & s) | (~(m ^ s) & bin);
        end else begin : g_mux
            // Equal bits pass the incoming borrow; differing bits borrow iff s is the 1.
            assign bout = (m == s) ? bin : s;
        end
    endgenerate

endmodule

module gt_slice_chain #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int          IMPL_TYPE      = 0
) (
    input  logic [BITS_PER_CYCLE-1:0] A,
    input  logic [BITS_PER_CYCLE-1:0] B,
    input  logic                      Bin,
    output logic                      Bout
);

    logic [BITS_PER_CYCLE:0] chain;

    assign chain[0] = Bin;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_bit
        subtractor_1bit_cmp #(
            .IMPL_TYPE(IMPL_TYPE)
        ) u_bit (
            .m   (B[g]),
            .s   (A[g]),
            .bin (chain[g]),
            .bout(chain[g+1])
        );
    end

    assign Bout = chain[BITS_PER_CYCLE];

endmodule

// File: rtl/gt_uint_serial_ctrl.sv
// Bit-serial unsigned A > B: one BITS_PER_CYCLE-wide borrow slice is reused for
// WIDTH/BITS_PER_CYCLE cycles, LSB slice first, computing the borrow of B - A.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (A, B sampled on the accept edge only)
//   out_valid/out_ready : result handshake
//   Y                   : 1 iff A > B, held until the next op completes
//   busy                : high while stepping
module gt_uint_serial_ctrl
    import gt_serial_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int          IMPL_TYPE      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Y,
    output logic             busy
);

    localparam int unsigned     NSTEP = nstep(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned     CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

    generate
        if (BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("gt_uint_serial_ctrl: WIDTH must be a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             borrow;
    logic             y_q;
    logic             slice_bout;
    logic             accept;

    gt_slice_chain #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE),
        .IMPL_TYPE     (IMPL_TYPE)
    ) u_chain (
        .A   (sa[BITS_PER_CYCLE-1:0]),
        .B   (sb[BITS_PER_CYCLE-1:0]),
        .Bin (borrow),
        .Bout(slice_bout)
    );

    // Registered state only; in_valid never reaches in_ready.
    assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign Y         = y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            borrow <= 1'b0;
            y_q    <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE and the back-to-back hand-off out of DONE.
            state  <= RUN;
            cnt    <= '0;
            sa     <= A;
            sb     <= B;
            borrow <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    borrow <= slice_bout;
                    sa     <= sa >> BITS_PER_CYCLE;
                    sb     <= sb >> BITS_PER_CYCLE;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        y_q   <= slice_bout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gt_uint_serial_ctrl.sv
module tb_gt_uint_serial_ctrl;

    localparam int NDUT = 7;

    // Instance table: 0=8/1 1=8/2 2=8/8 3=32/1 4=32/2 5=32/8 6=32/4
    function automatic int unsigned wd(input int d);
        case (d)
            0, 1, 2: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned bp(input int d);
        case (d)
            0: return 1;
            1: return 2;
            2: return 8;
            3: return 1;
            4: return 2;
            5: return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] msk(input int d);
        logic [31:0] one;
        one = 32'd1;
        if (wd(d) == 32) return 32'hFFFF_FFFF;
        return (one << wd(d)) - 32'd1;
    endfunction

    logic            clk;
    logic            rst_n;
    logic [NDUT-1:0] in_valid;
    logic [NDUT-1:0] in_ready;
    logic [NDUT-1:0] out_valid;
    logic [NDUT-1:0] out_ready;
    logic [NDUT-1:0] y;
    logic [NDUT-1:0] busy;
    logic [31:0]     a_bus;
    logic [31:0]     b_bus;

    int n_pass  = 0;
    int n_total = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned W   = wd(g);
        localparam int unsigned BPC = bp(g);
        gt_uint_serial_ctrl #(
            .WIDTH         (W),
            .BITS_PER_CYCLE(BPC),
            .IMPL_TYPE     (g % 2)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .A        (a_bus[W-1:0]),
            .B        (b_bus[W-1:0]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .Y        (y[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_y;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_accept", 32'(in_ready[d]), 32'd1);
        a_bus       = a;
        b_bus       = b;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
    endtask

    // Returns edges after the accept edge at which out_valid was first seen.
    task automatic wait_result(input int d, output int lat);
        lat = 0;
        @(negedge clk);
        check("busy_in_run", 32'(busy[d]), 32'd1);
        while (!out_valid[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1 out_ready[d] = 1'b0;
    endtask

    task automatic run_vec(input int d, input logic [31:0] a, input logic [31:0] b,
                           input logic exp_y, input string name);
        int lat;
        start_op(d, a, b);
        wait_result(d, lat);
        check({name, "_latency"}, 32'(lat), 32'(wd(d) / bp(d)));
        check({name, "_y"}, 32'(y[d]), 32'(exp_y));
        finish_op(d);
    endtask

    initial begin
        vec_t vecs[12];
        int   lat;
        int   seen;
        int   idx;
        logic [31:0] ops_a[3];
        logic [31:0] ops_b[3];
        logic        res_y[$];
        int          res_t[$];

        vecs[0]  = '{0, 32'd5,          32'd3,          1'b1};
        vecs[1]  = '{0, 32'hFF,         32'hFF,         1'b0};
        vecs[2]  = '{6, 32'h8000_0000,  32'h7FFF_FFFF,  1'b1};
        vecs[3]  = '{6, 32'h7FFF_FFFF,  32'h8000_0000,  1'b0};
        vecs[4]  = '{6, 32'h0,          32'hFFFF_FFFF,  1'b0};
        vecs[5]  = '{6, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1};
        vecs[6]  = '{2, 32'h0,          32'h0,          1'b0};
        vecs[7]  = '{5, 32'h1234_5678,  32'h1234_5678,  1'b0};
        vecs[8]  = '{3, 32'hFFFF_FFFF,  32'h0,          1'b1};
        vecs[9]  = '{4, 32'h1,          32'h0,          1'b1};
        vecs[10] = '{1, 32'h80,         32'h7F,         1'b1};
        vecs[11] = '{0, 32'h0,          32'h1,          1'b0};

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        a_bus     = '0;
        b_bus     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_release_in_ready", 32'(in_ready), 32'h7F);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].exp_y, $sformatf("vec%0d", i));
        end

        // Backpressure; in_valid held during RUN/stall with other operands must be ignored
        start_op(0, 32'd5, 32'd3);
        a_bus       = 32'd0;
        b_bus       = 32'hFF;
        in_valid[0] = 1'b1;
        wait_result(0, lat);
        check("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid[0]), 32'd1);
            check("bp_y", 32'(y[0]), 32'd1);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_after_out_valid", 32'(out_valid[0]), 32'd0);
        check("bp_after_in_ready", 32'(in_ready[0]), 32'd1);
        check("bp_after_busy", 32'(busy[0]), 32'd0);
        check("bp_after_y_held", 32'(y[0]), 32'd1);

        // Back-to-back on 8/2: 9>4, 4>9, 7>7
        ops_a = '{32'd9, 32'd4, 32'd7};
        ops_b = '{32'd4, 32'd9, 32'd7};
        idx   = 0;
        @(negedge clk);
        a_bus        = ops_a[0];
        b_bus        = ops_b[0];
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (out_valid[1]) begin
                res_y.push_back(y[1]);
                res_t.push_back(cyc);
            end
            if (in_ready[1] && in_valid[1]) begin
                idx++;
                @(posedge clk);
                #1;
                if (idx < 3) begin
                    a_bus = ops_a[idx];
                    b_bus = ops_b[idx];
                end else begin
                    in_valid[1] = 1'b0;
                end
            end
        end
        out_ready[1] = 1'b0;
        check("b2b_accepts", 32'(idx), 32'd3);
        check("b2b_results", 32'(res_y.size()), 32'd3);
        if (res_y.size() == 3) begin
            check("b2b_y0", 32'(res_y[0]), 32'd1);
            check("b2b_y1", 32'(res_y[1]), 32'd0);
            check("b2b_y2", 32'(res_y[2]), 32'd0);
            check("b2b_gap01", 32'(res_t[1] - res_t[0]), 32'd5);
            check("b2b_gap12", 32'(res_t[2] - res_t[1]), 32'd5);
        end

        // Reset mid-op: 200 > 1 would give Y=1, dropped at step 3
        start_op(0, 32'd200, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_y", 32'(y[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_in_ready_low", 32'(in_ready[0]), 32'd0);
        rst_n = 1'b1;
        #1 check("midrst_release_in_ready", 32'(in_ready[0]), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_vec(0, 32'd2, 32'd1, 1'b1, "midrst_new_op");

        // Random against a > reference
        for (int i = 0; i < 1800; i++) begin
            int          d;
            int          sel;
            logic [31:0] ra;
            logic [31:0] rb;
            d   = $urandom_range(0, 5);
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            case (sel)
                0:       rb = ra;
                1:       rb = ra - 32'd1;
                2:       rb = ra + 32'd1;
                default: rb = $urandom;
            endcase
            ra = ra & msk(d);
            rb = rb & msk(d);
            run_vec(d, ra, rb, ra > rb, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
